ram: RTL and testbench

RAM -- requirements
Module: ram

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_if.sv | 39 +++
 rtl/ram_byte_lane.sv | 38 +++
 rtl/ram.sv | 59 +++++
 tb/tb_ram.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the byte-lane RAM.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default geometry
//   BYTE_W                          : width of one byte lane
//   LANES_DEF                       : lane count for the default width
//   word_t                          : one default-width memory word
package ram_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LANES_DEF      = DATA_WIDTH_DEF / BYTE_W;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

  // Number of byte lanes for a given word width
  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_if.sv
// ram_if: access bus of the RAM.
//   i_addr    : word address (read and write)
//   i_data    : write data
//   i_we      : write enable
//   i_be      : byte-lane write enable (only with RAM_BYTE_WE_EN)
//   o_ramdata : combinational read data
// Macro RAM_BYTE_WE_EN adds the i_be signal.
interface ram_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic [ADDR_WIDTH-1:0]        i_addr;
  logic [DATA_WIDTH-1:0]        i_data;
  logic                         i_we;
`ifdef RAM_BYTE_WE_EN
  logic [DATA_WIDTH/BYTE_W-1:0] i_be;
`endif
  logic [DATA_WIDTH-1:0]        o_ramdata;

  modport master (
`ifdef RAM_BYTE_WE_EN
    output i_be,
`endif
    output i_addr, i_data, i_we,
    input  o_ramdata
  );

  modport slave (
`ifdef RAM_BYTE_WE_EN
    input  i_be,
`endif
    input  i_addr, i_data, i_we,
    output o_ramdata
  );

endinterface

// File: rtl/ram_byte_lane.sv
// ram_byte_lane: one 8-bit column of the RAM with its own write enable.
//   i_clk  : clock, writes on rising edge
//   i_rst  : async active-high reset, clears the whole column
//   i_we   : lane write enable (global write AND lane enable)
//   i_addr : word address
//   i_data : byte to write
//   o_col  : full column contents, read mux lives in the parent
module ram_byte_lane
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BYTE_W-1:0]     i_data,
  output logic [BYTE_W-1:0]     o_col [1 << ADDR_WIDTH]
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [BYTE_W-1:0] r_mem [DEPTH];

  // Column storage; reset clears every entry so reads return zero immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  assign o_col = r_mem;

endmodule

// File: rtl/ram.sv
// ram: single-clock RAM built from byte-lane columns, asynchronous read.
//   i_clk : clock, writes on rising edge
//   i_rst : async active-high reset, clears all words
//   bus   : ram_if slave (i_addr, i_data, i_we, [i_be], o_ramdata)
// Macro RAM_BYTE_WE_EN enables per-lane write masking through bus.i_be;
// without it every write updates the full word.
module ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  ram_if.slave bus
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_width
    $error("ram: DATA_WIDTH must be a multiple of 8");
  end

  logic [LANES-1:0]      w_be;
  logic [BYTE_W-1:0]     w_cols [LANES][DEPTH];
  logic [DATA_WIDTH-1:0] w_rdata;

`ifdef RAM_BYTE_WE_EN
  assign w_be = bus.i_be;
`else
  assign w_be = '1;
`endif

  // One storage column per byte lane
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    ram_byte_lane #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_we   (bus.i_we & w_be[l]),
      .i_addr (bus.i_addr),
      .i_data (bus.i_data[l*BYTE_W +: BYTE_W]),
      .o_col  (w_cols[l])
    );
  end

  // Read mux: pick the addressed entry of every column; no write bypass
  always_comb begin
    w_rdata = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_rdata[l*BYTE_W +: BYTE_W] = w_cols[l][bus.i_addr];
    end
  end

  assign bus.o_ramdata = w_rdata;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed test of ram with a queue-based scoreboard.
module tb_ram;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic strobe = 1'b0;

  always #5 clk = ~clk;

  ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  ram #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: compare the DUT read port against the oldest expectation
  always @(posedge strobe) begin
    exp_t e;
    n_total++;
    if (q.size() == 0) begin
      $display("FAIL sb_underflow: strobe with empty queue, o_ramdata=%h", bus.o_ramdata);
    end else begin
      e = q.pop_front();
      if (bus.o_ramdata === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, bus.o_ramdata, e.exp);
    end
  end

  task automatic check(input string nm, input logic [31:0] ex);
    q.push_back('{nm, ex});
    strobe = 1'b1;
    #1 strobe = 1'b0;
  endtask

  // Start/end: 1 time unit after a rising edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.i_addr = a;
    bus.i_data = d;
    bus.i_we   = 1'b1;
`ifdef RAM_BYTE_WE_EN
    bus.i_be   = be;
`else
    if (be == 4'h0) bus.i_we = 1'b0;
`endif
    @(posedge clk);
    #1 bus.i_we = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] ex);
    bus.i_addr = a;
    bus.i_we   = 1'b0;
    @(negedge clk);
    check(nm, ex);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    bus.i_addr = 5'd3;
    bus.i_data = 32'h5555_5555;
    bus.i_we   = 1'b1;
`ifdef RAM_BYTE_WE_EN
    bus.i_be   = 4'hF;
`endif
    // Write attempted during reset must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_addr3", 32'h0);
    bus.i_we = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;

    rd("rst_addr3",  5'd3,  32'h0);
    rd("rst_addr0",  5'd0,  32'h0);
    rd("rst_addr5",  5'd5,  32'h0);
    rd("rst_addr31", 5'd31, 32'h0);

    wr(5'd5, 32'h1234_5678, 4'hF);
    rd("wr_addr5", 5'd5, 32'h1234_5678);

    // Back-to-back writes to different addresses
    wr(5'd31, 32'hDEAD_BEEF, 4'hF);
    wr(5'd0,  32'h0000_0001, 4'hF);
    rd("wr_addr31",   5'd31, 32'hDEAD_BEEF);
    rd("wr_addr0",    5'd0,  32'h0000_0001);
    rd("keep_addr5",  5'd5,  32'h1234_5678);

    // we=0 with new data leaves memory untouched
    bus.i_addr = 5'd5;
    bus.i_data = 32'hFFFF_FFFF;
    bus.i_we   = 1'b0;
    @(posedge clk);
    #1;
    rd("we0_addr5", 5'd5, 32'h1234_5678);

    // Read-during-write: old word before the edge, new word after
    bus.i_addr = 5'd9;
    bus.i_data = 32'h9999_0009;
    bus.i_we   = 1'b1;
    @(negedge clk);
    check("rdw_before", 32'h0);
    @(posedge clk);
    #1 bus.i_we = 1'b0;
    check("rdw_after", 32'h9999_0009);

    // Byte-lane masking (full-word write without the feature)
`ifdef RAM_BYTE_WE_EN
    wr(5'd12, 32'h1122_3344, 4'b1111);
    wr(5'd12, 32'hFFFF_FFFF, 4'b0101);
    rd("be_mask", 5'd12, 32'h11FF_33FF);
    wr(5'd12, 32'h0000_0000, 4'b0000);
    rd("be_none", 5'd12, 32'h11FF_33FF);
`else
    wr(5'd12, 32'h1122_3344, 4'hF);
    wr(5'd12, 32'hCAFE_F00D, 4'hF);
    rd("full_word", 5'd12, 32'hCAFE_F00D);
`endif

    // Async reset mid-cycle clears immediately
    wr(5'd7, 32'hAAAA_AAAA, 4'hF);
    bus.i_addr = 5'd7;
    @(negedge clk);
    check("pre_rst_addr7", 32'hAAAA_AAAA);
    rst = 1'b1;
    #1;
    check("async_rst_addr7", 32'h0);
    @(negedge clk);
    bus.i_addr = 5'd31;
    #1;
    check("rst_addr31_again", 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First write after reset behaves normally, old contents gone
    wr(5'd7, 32'h0BAD_F00D, 4'hF);
    rd("post_rst_wr7", 5'd7, 32'h0BAD_F00D);
    rd("post_rst_addr5", 5'd5, 32'h0);

    #2;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: %0d entries remain, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
